// File: rtl/ext_pkg.sv
// Shared constants for the immediate/offset extender: mode encodings and result layout.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ext_pkg;

  localparam int EXT_SEL_W = 3;

  localparam logic [EXT_SEL_W-1:0] EXT_UNSIGNED = 3'd0;
  localparam logic [EXT_SEL_W-1:0] EXT_SIGNED   = 3'd1;
  localparam logic [EXT_SEL_W-1:0] EXT_POS_H    = 3'd2;
  localparam logic [EXT_SEL_W-1:0] EXT_BR_OFF   = 3'd3;
  localparam logic [EXT_SEL_W-1:0] EXT_JTARGET  = 3'd4;
  localparam logic [EXT_SEL_W-1:0] EXT_LB       = 3'd5;
  localparam logic [EXT_SEL_W-1:0] EXT_LBU      = 3'd6;
  localparam logic [EXT_SEL_W-1:0] EXT_LH       = 3'd7;

  // Result layout at the default 32-bit datapath width; the top level
  // declares the same {data, err} layout sized by its DATA_W parameter.
  localparam int EXT_DEF_DATA_W = 32;

  typedef struct packed {
    logic [EXT_DEF_DATA_W-1:0] data;
    logic                      err;
  } ext_res_t;

endpackage

// File: rtl/ext_skid_buf.sv
// Two-entry strict-FIFO valid/ready buffer for the extender result payload.
// Latency: push in cycle N is visible at the output in N+1 when the buffer was empty.
// Backpressure: in_rdy_o = (count != 2) from registered count only; no path from out_rdy_i.
module ext_skid_buf #(
  parameter int W = 33
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_vld_i,
  output logic         in_rdy_o,
  input  logic [W-1:0] in_dat_i,
  output logic         out_vld_o,
  input  logic         out_rdy_i,
  output logic [W-1:0] out_dat_o
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] head_q, head_d;   // oldest entry, drives the output
  logic [W-1:0] tail_q, tail_d;   // second entry, valid only when count == 2
  logic         push, pop;

  assign in_rdy_o  = (count_q != 2'd2);
  assign out_vld_o = (count_q != 2'd0);
  assign out_dat_o = head_q;

  assign push = in_vld_i && in_rdy_o;
  assign pop  = out_vld_o && out_rdy_i;

  // Next-state: head keeps its last value when the buffer drains so the output holds.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
      if (count_q == 2'd0) begin
        head_d = in_dat_i;
      end else begin
        tail_d = in_dat_i;
      end
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
      if (count_q == 2'd2) begin
        head_d = tail_q;
      end
    end else if (push && pop) begin
      // Only reachable at count 1: head leaves, new entry becomes head.
      head_d = in_dat_i;
    end
  end

  // State register; reset empties the buffer and clears the visible payload.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/ext_imm_pipe.sv
// Immediate/offset extender (zero, sign, upper, branch, jump; EXT_LOAD_MODES_EN adds LB/LBU/LH).
// Latency: 1 cycle from accepted request to out_valid when the buffer is empty.
// Backpressure: 2-entry buffer; in_ready drops when full and rises the cycle after a pop.
module ext_imm_pipe
  import ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int JT_W   = 26,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [JT_W-1:0]      in_imm,
  input  logic [EXT_SEL_W-1:0] in_sel,
  input  logic [DATA_W-1:0]    in_pc_hi,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_err
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } res_t;

  res_t              res;
  res_t              buf_out;
  logic [IMM_W-1:0]  s_imm;
  logic [DATA_W-1:0] zext;
  logic [DATA_W-1:0] sext;
  logic              unused_pc_lo;

  assign s_imm = in_imm[IMM_W-1:0];
  assign zext  = {{(DATA_W-IMM_W){1'b0}}, s_imm};
  assign sext  = {{(DATA_W-IMM_W){s_imm[IMM_W-1]}}, s_imm};

  // Low PC bits are replaced by the jump field and word alignment.
  assign unused_pc_lo = ^in_pc_hi[JT_W+1:0];

  // Extension function: every mode, legal or not, drives a full result.
  always_comb begin
    res.data = '0;
    res.err  = 1'b0;
    case (in_sel)
      EXT_UNSIGNED: res.data = zext;
      EXT_SIGNED:   res.data = sext;
      EXT_POS_H:    res.data = {s_imm, {(DATA_W-IMM_W){1'b0}}};
      EXT_BR_OFF:   res.data = {sext[DATA_W-3:0], 2'b00};
      EXT_JTARGET:  res.data = {in_pc_hi[DATA_W-1:JT_W+2], in_imm, 2'b00};
`ifdef EXT_LOAD_MODES_EN
      EXT_LB:       res.data = {{(DATA_W-8){in_imm[7]}}, in_imm[7:0]};
      EXT_LBU:      res.data = {{(DATA_W-8){1'b0}}, in_imm[7:0]};
      EXT_LH:       res.data = {{(DATA_W-16){in_imm[15]}}, in_imm[15:0]};
      default: begin
        res.data = '0;
        res.err  = 1'b0;
      end
`else
      default: begin
        res.data = '0;
        res.err  = 1'b1;
      end
`endif
    endcase
  end

  ext_skid_buf #(
    .W ($bits(res_t))
  ) u_buf (
    .clk_i     (clk),
    .rst_i     (rst),
    .in_vld_i  (in_valid),
    .in_rdy_o  (in_ready),
    .in_dat_i  (res),
    .out_vld_o (out_valid),
    .out_rdy_i (out_ready),
    .out_dat_o (buf_out)
  );

  assign out_data = buf_out.data;
  assign out_err  = buf_out.err;

endmodule

// File: tb/tb_ext_imm_pipe.sv
// Scoreboard bench for ext_imm_pipe: directed modes, backpressure, reset flush, random stream.
// Latency: checks one-cycle result visibility on an empty buffer.
// Backpressure: out_ready is held low or randomised to exercise the full/stall paths.
module tb_ext_imm_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [25:0] in_imm;
  logic [2:0]  in_sel;
  logic [31:0] in_pc_hi;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  logic [32:0] sb[$];

  logic        stall_seen;
  logic [32:0] stall_val;

  ext_imm_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_sel    (in_sel),
    .in_pc_hi  (in_pc_hi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model for the default 16/26/32 configuration, result = {err, data}.
  function automatic logic [32:0] model(input logic [2:0] sel, input logic [25:0] imm,
                                        input logic [31:0] pc);
    logic signed [31:0] s;
    logic [32:0] r;
    r = '0;
    case (sel)
      3'd0: r = {1'b0, 16'h0000, imm[15:0]};
      3'd1: begin s = $signed(imm[15:0]); r = {1'b0, s}; end
      3'd2: r = {1'b0, imm[15:0], 16'h0000};
      3'd3: begin s = $signed(imm[15:0]); s = s * 4; r = {1'b0, s}; end
      3'd4: r = {1'b0, pc[31:28], imm, 2'b00};
`ifdef EXT_LOAD_MODES_EN
      3'd5: begin s = $signed(imm[7:0]);  r = {1'b0, s}; end
      3'd6: r = {1'b0, 24'h000000, imm[7:0]};
      3'd7: begin s = $signed(imm[15:0]); r = {1'b0, s}; end
`else
      default: r = {1'b1, 32'h0};
`endif
    endcase
    return r;
  endfunction

  // Scoreboard: record accepted requests, compare results as they are consumed,
  // and require a stalled output to hold steady.
  always @(negedge clk) begin
    if (rst) begin
      stall_seen <= 1'b0;
    end else begin
      if (stall_seen && out_valid)
        check("stall_stable", {31'd0, out_err, out_data}, {31'd0, stall_val});
      if (in_valid && in_ready)
        sb.push_back(model(in_sel, in_imm, in_pc_hi));
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          check("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          check("sb_data", {31'd0, out_err, out_data}, {31'd0, sb.pop_front()});
        end
      end
      stall_seen <= out_valid && !out_ready;
      stall_val  <= {out_err, out_data};
    end
  end

  task automatic send(input logic [2:0] sel, input logic [25:0] imm, input logic [31:0] pc);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_imm   = imm;
    in_pc_hi = pc;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b0;
    in_sel   = $urandom_range(0, 7);
    in_imm   = $urandom;
  endtask

  task automatic send_chk(input string tag, input logic [2:0] sel, input logic [25:0] imm,
                          input logic [31:0] pc, input logic [31:0] exp_data, input logic exp_err);
    out_ready = 1'b1;
    send(sel, imm, pc);
    check({tag, "_vld"},  {63'd0, out_valid}, 64'd1);
    check({tag, "_data"}, {32'd0, out_data},  {32'd0, exp_data});
    check({tag, "_err"},  {63'd0, out_err},   {63'd0, exp_err});
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  bit rnd_done;
  int n_before;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_sel    = '0;
    in_pc_hi  = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_out_data",  {32'd0, out_data},  64'd0);
    check("rst_out_err",   {63'd0, out_err},   64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send_chk("t1_signed", 3'd1, 26'h0008001, 32'h0, 32'hFFFF8001, 1'b0);
    send_chk("t2_pos_h",  3'd2, 26'h0001234, 32'h0, 32'h12340000, 1'b0);
    send_chk("t2_br_off", 3'd3, 26'h000FFFF, 32'h0, 32'hFFFFFFFC, 1'b0);
    send_chk("t2_uns",    3'd0, 26'h3FF8001, 32'h0, 32'h00008001, 1'b0);
    send_chk("t3_jtgt",   3'd4, 26'h0000ABC, 32'hA0000000, 32'hA0002AF0, 1'b0);
`ifdef EXT_LOAD_MODES_EN
    send_chk("t6_lb",     3'd5, 26'h0000080, 32'h0, 32'hFFFFFF80, 1'b0);
`else
    send_chk("t6_lb",     3'd5, 26'h0000080, 32'h0, 32'h00000000, 1'b1);
`endif
    drain();

    // Backpressure: two fill the buffer, the third must wait for a pop.
    n_before  = n_out;
    out_ready = 1'b0;
    send(3'd0, 26'h0000011, 32'h0);
    check("t4_rdy_after1", {63'd0, in_ready}, 64'd1);
    send(3'd1, 26'h0000F22, 32'h0);
    check("t4_rdy_after2", {63'd0, in_ready}, 64'd0);
    fork
      send(3'd2, 26'h0000033, 32'h0);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("t4_full_hold", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
      end
    join
    drain();
    check("t4_count", 64'(n_out - n_before), 64'd3);

    // Reset with two entries buffered.
    out_ready = 1'b0;
    send(3'd1, 26'h000FFFF, 32'h0);
    send(3'd3, 26'h0000123, 32'h0);
    check("t5_full", {63'd0, out_valid & ~in_ready}, 64'd1);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_out_valid", {63'd0, out_valid}, 64'd0);
    check("t5_in_ready",  {63'd0, in_ready},  64'd1);
    check("t5_out_data",  {32'd0, out_data},  64'd0);
    check("t5_out_err",   {63'd0, out_err},   64'd0);

    // Random stream with random consumer stalls.
    n_before = n_out;
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 60; k++)
          send(3'($urandom_range(0, 7)), 26'($urandom), $urandom);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    check("rnd_count", 64'(n_out - n_before), 64'd60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
